// File: rtl/spi_master_ctrl.sv
// SPI mode-1 (CPOL=0, CPHA=1) master sequencer: drives SCLK/CS_n/MOSI, gates the receive
// shifter and captures its parallel word. Optional transfer counter: define SPI_XFER_CNT_EN.
module spi_master_ctrl #(
  parameter int WIDTH    = 8,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int SETTLE   = 3
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic [WIDTH-1:0] rx_data_i,
  output logic             SCLK_o,
  output logic             CS_n_o,
  output logic             MOSI_o,
  output logic             rx_en_o,
  output logic             busy_o,
  output logic             done_o,
`ifdef SPI_XFER_CNT_EN
  output logic [WIDTH-1:0] rx_data_o,
  output logic [15:0]      xfer_count_o
`else
  output logic [WIDTH-1:0] rx_data_o
`endif
);

  localparam int PH_MAX0 = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int PH_MAX  = (PH_MAX0 > SETTLE) ? PH_MAX0 : SETTLE;
  localparam int PH_W    = $clog2(PH_MAX);
  localparam int BIT_W   = $clog2(WIDTH);

  localparam logic [PH_W-1:0]  SETUP_LD  = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0]  DIV_LD    = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  SETTLE_LD = PH_W'(SETTLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCLK_HI,
    SCLK_LO,
    WAIT,
    HOLD
  } state_t;

  state_t           state;
  logic [PH_W-1:0]  phase;
  logic [BIT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      phase     <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      SCLK_o    <= 1'b0;
      CS_n_o    <= 1'b1;
      MOSI_o    <= 1'b0;
      rx_en_o   <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      rx_data_o <= '0;
`ifdef SPI_XFER_CNT_EN
      xfer_count_o <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state   <= SETUP;
            phase   <= SETUP_LD;
            bit_cnt <= '0;
            shreg   <= tx_data_i;
            busy_o  <= 1'b1;
            CS_n_o  <= 1'b0;
            rx_en_o <= 1'b1;
          end
        end
        SETUP: begin
          if (phase == '0) begin
            state  <= SCLK_HI;
            phase  <= DIV_LD;
            SCLK_o <= 1'b1;
            MOSI_o <= shreg[WIDTH-1];
          end else begin
            phase <= phase - 1'b1;
          end
        end
        SCLK_HI: begin
          if (phase == '0) begin
            state  <= SCLK_LO;
            phase  <= DIV_LD;
            SCLK_o <= 1'b0;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        SCLK_LO: begin
          if (phase == '0) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            if (bit_cnt == LAST_BIT) begin
              state <= WAIT;
              phase <= SETTLE_LD;
            end else begin
              // next MSB is shreg[WIDTH-2] since the shift lands in the same edge
              bit_cnt <= bit_cnt + 1'b1;
              state   <= SCLK_HI;
              phase   <= DIV_LD;
              SCLK_o  <= 1'b1;
              MOSI_o  <= shreg[WIDTH-2];
            end
          end else begin
            phase <= phase - 1'b1;
          end
        end
        WAIT: begin
          if (phase == '0) begin
            state     <= HOLD;
            phase     <= DIV_LD;
            rx_data_o <= rx_data_i;
            done_o    <= 1'b1;
            CS_n_o    <= 1'b1;
            rx_en_o   <= 1'b0;
            MOSI_o    <= 1'b0;
`ifdef SPI_XFER_CNT_EN
            xfer_count_o <= xfer_count_o + 16'd1;
`endif
          end else begin
            phase <= phase - 1'b1;
          end
        end
        HOLD: begin
          if (phase == '0) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: an 8-bit instance (CLK_DIV=2) and a 2-bit edge instance,
// each with a sysclk-sampled receive-shifter/slave model.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       start = 1'b0;
  logic [7:0] tx_data = '0;
  logic [7:0] rx_in;
  logic       sclk, cs_n, mosi, rx_en, busy, done;
  logic [7:0] rx_data;
`ifdef SPI_XFER_CNT_EN
  logic [15:0] xcnt, xcnt2;
`endif

  spi_master_ctrl #(.WIDTH(8), .CLK_DIV(2), .CS_SETUP(2), .SETTLE(3)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .tx_data_i(tx_data), .rx_data_i(rx_in),
    .SCLK_o(sclk), .CS_n_o(cs_n), .MOSI_o(mosi), .rx_en_o(rx_en), .busy_o(busy),
    .done_o(done),
`ifdef SPI_XFER_CNT_EN
    .rx_data_o(rx_data), .xfer_count_o(xcnt)
`else
    .rx_data_o(rx_data)
`endif
  );

  // 2-bit edge instance
  logic       start2 = 1'b0;
  logic [1:0] tx2 = '0;
  logic [1:0] rx_in2;
  logic       sclk2, cs_n2, mosi2, rx_en2, busy2, done2;
  logic [1:0] rx_data2;

  spi_master_ctrl #(.WIDTH(2), .CLK_DIV(2), .CS_SETUP(2), .SETTLE(3)) dut2 (
    .clock_i(clk), .reset_i(rst), .start_i(start2), .tx_data_i(tx2), .rx_data_i(rx_in2),
    .SCLK_o(sclk2), .CS_n_o(cs_n2), .MOSI_o(mosi2), .rx_en_o(rx_en2), .busy_o(busy2),
    .done_o(done2),
`ifdef SPI_XFER_CNT_EN
    .rx_data_o(rx_data2), .xfer_count_o(xcnt2)
`else
    .rx_data_o(rx_data2)
`endif
  );

  // Slave + receive shifter: shifts on detected SCLK fall, one sysclk of latency.
  logic [7:0] slave8 = '0;
  logic [7:0] rx_sh = '0, mosi_sh = '0;
  logic [2:0] idx = '0;
  logic       sclk_d = 1'b0;
  always @(posedge clk) begin
    sclk_d <= sclk;
    if (cs_n) idx <= '0;
    else if (sclk_d && !sclk && rx_en) begin
      rx_sh   <= {rx_sh[6:0], slave8[3'd7 - idx]};
      mosi_sh <= {mosi_sh[6:0], mosi};
      idx     <= idx + 3'd1;
    end
  end
  assign rx_in = rx_sh;

  logic [1:0] slave2 = '0;
  logic [1:0] rx_sh2 = '0, mosi_sh2 = '0;
  logic       idx2 = 1'b0;
  logic       sclk2_d = 1'b0;
  always @(posedge clk) begin
    sclk2_d <= sclk2;
    if (cs_n2) idx2 <= 1'b0;
    else if (sclk2_d && !sclk2 && rx_en2) begin
      rx_sh2   <= {rx_sh2[0], slave2[1'b1 - idx2]};
      mosi_sh2 <= {mosi_sh2[0], mosi2};
      idx2     <= idx2 + 1'b1;
    end
  end
  assign rx_in2 = rx_sh2;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // results of run_big
  int         r_first_rise, r_rises, r_falls, r_done_k, r_ndone, r_cs_edges;
  logic       r_busy39, r_busy40;
  logic [7:0] r_rx, r_mosi;
  logic [15:0] r_cnt_before, r_cnt_at;

  // Start one transfer in the current cycle T; observe cycles T+1..T+ncyc.
  task automatic run_big(input logic [7:0] tx, input logic [7:0] slv, input int pulse_at,
                         input int ncyc);
    logic prev;
    tx_data = tx;
    slave8  = slv;
    start   = 1'b1;
    prev    = sclk;
    r_first_rise = -1; r_rises = 0; r_falls = 0; r_done_k = -1; r_ndone = 0; r_cs_edges = 0;
    r_busy39 = 1'bx; r_busy40 = 1'bx; r_rx = 'x; r_mosi = 'x;
    r_cnt_before = '0; r_cnt_at = '0;
    for (int k = 1; k <= ncyc; k++) begin
`ifdef SPI_XFER_CNT_EN
      r_cnt_before = (r_ndone == 0) ? xcnt : r_cnt_before;
`endif
      tick();
      if (k == 1) start = 1'b0;
      if (pulse_at > 0 && k == pulse_at) begin
        start = 1'b1;
        tx_data = 8'hFF;
      end
      if (pulse_at > 0 && k == pulse_at + 1) start = 1'b0;
      if (sclk && !prev) begin
        r_rises++;
        if (r_first_rise < 0) r_first_rise = k;
      end
      if (!sclk && prev) r_falls++;
      if (cs_n && (sclk != prev)) r_cs_edges++;
      if (done) begin
        r_ndone++;
        r_done_k = k;
        r_rx = rx_data;
        r_mosi = mosi_sh;
`ifdef SPI_XFER_CNT_EN
        r_cnt_at = xcnt;
`endif
      end
      if (k == 39) r_busy39 = busy;
      if (k == 40) r_busy40 = busy;
      prev = sclk;
    end
  endtask

  int d1, d2, nd, cs_gap, rises2, done2_k;
  logic [7:0] rx1, rx2, m1, m2;
  logic       p2;

  initial begin
    // reset state
    tick(); tick();
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_rx_en", 32'(rx_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    tick(); tick();

    // basic transfer, with a start pulse at T+10 that must be ignored
    run_big(8'hA5, 8'h3C, 10, 80);
    check("basic_first_rise", 32'(r_first_rise), 32'd3);
    check("basic_rises", 32'(r_rises), 32'd8);
    check("basic_falls", 32'(r_falls), 32'd8);
    check("basic_done_cycle", 32'(r_done_k), 32'd38);
    check("basic_done_count", 32'(r_ndone), 32'd1);
    check("basic_rx_data", 32'(r_rx), 32'h3C);
    check("basic_mosi", 32'(r_mosi), 32'hA5);
    check("basic_busy_39", 32'(r_busy39), 32'd1);
    check("basic_busy_40", 32'(r_busy40), 32'd0);
    check("basic_cs_edges", 32'(r_cs_edges), 32'd0);

    // back-to-back with start held high
    tx_data = 8'h01; slave8 = 8'hAA; start = 1'b1;
    nd = 0; cs_gap = 0; d1 = -1; d2 = -1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (nd == 1 && cs_n) cs_gap++;
      if (done) begin
        nd++;
        if (nd == 1) begin
          d1 = k; rx1 = rx_data; m1 = mosi_sh;
          cs_gap = 1;
          tx_data = 8'h80; slave8 = 8'h55;
        end else if (nd == 2) begin
          d2 = k; rx2 = rx_data; m2 = mosi_sh;
          start = 1'b0;
        end
      end
    end
    check("b2b_done_count", 32'(nd), 32'd2);
    check("b2b_first_done", 32'(d1), 32'd38);
    check("b2b_spacing", 32'(d2 - d1), 32'd40);
    check("b2b_rx1", 32'(rx1), 32'hAA);
    check("b2b_rx2", 32'(rx2), 32'h55);
    check("b2b_mosi1", 32'(m1), 32'h01);
    check("b2b_mosi2", 32'(m2), 32'h80);
    check("b2b_cs_gap_ge2", 32'(cs_gap >= 2), 32'd1);
    check("b2b_idle_after", 32'(busy), 32'd0);

    // reset during the 4th SCLK high phase
    tx_data = 8'h5A; slave8 = 8'h99; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 2; k <= 15; k++) tick();
    check("rstmid_sclk_before", 32'(sclk), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("rstmid_cs_n", 32'(cs_n), 32'd1);
    check("rstmid_sclk", 32'(sclk), 32'd0);
    check("rstmid_rx_data", 32'(rx_data), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    tick(); tick();
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (done) nd++;
    end
    check("rstmid_no_done", 32'(nd), 32'd0);
    check("rstmid_rx_held0", 32'(rx_data), 32'd0);

    run_big(8'h3C, 8'hC3, 0, 45);
    check("post_rst_done_cycle", 32'(r_done_k), 32'd38);
    check("post_rst_rx", 32'(r_rx), 32'hC3);
    check("post_rst_mosi", 32'(r_mosi), 32'h3C);
    check("post_rst_rises", 32'(r_rises), 32'd8);

    // WIDTH=2 edge instance: done at T+1+2+8+3 = T+14
    tx2 = 2'b10; slave2 = 2'b01; start2 = 1'b1;
    rises2 = 0; done2_k = -1; p2 = sclk2;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 1) start2 = 1'b0;
      if (sclk2 && !p2) rises2++;
      if (done2) done2_k = k;
      p2 = sclk2;
    end
    check("w2_rises", 32'(rises2), 32'd2);
    check("w2_done_cycle", 32'(done2_k), 32'd14);
    check("w2_rx", 32'(rx_data2), 32'h1);
    check("w2_mosi", 32'(mosi_sh2), 32'h2);

`ifdef SPI_XFER_CNT_EN
    force dut.xfer_count_o = 16'hFFFC;
    tick();
    release dut.xfer_count_o;
    run_big(8'h11, 8'h22, 0, 42);
    run_big(8'h33, 8'h44, 0, 42);
    check("cnt_preload", 32'(xcnt), 32'hFFFE);
    run_big(8'h55, 8'h66, 0, 42);
    check("cnt_before_ffff", 32'(r_cnt_before), 32'hFFFE);
    check("cnt_at_done_ffff", 32'(r_cnt_at), 32'hFFFF);
    run_big(8'h77, 8'h88, 0, 42);
    check("cnt_before_wrap", 32'(r_cnt_before), 32'hFFFF);
    check("cnt_at_done_wrap", 32'(r_cnt_at), 32'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
